// File: rtl/tdp_bram_bist.sv
// tdp_bram_bist: built-in self-test engine for one true-dual-port block RAM.
// Both RAM ports share the BIST clock. The test runs in three phases:
//   1. Each port writes its own half of the RAM with P(addr).
//   2. Each port reads its own half back.
//   3. Cross-read: A reads the upper half and B reads the lower half.
// Each port counts its own mismatches and records the first failing address.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start_i              start pulse, accepted only in idle/done
//   busy_o, done_o       run in progress / run finished
//   pass_o               valid with done_o, 1 iff no mismatches on either port
//   a_*_o / b_*_o        RAM port A/B address, write enable, read enable, write data
//   a_rdata_i, b_rdata_i RAM port A/B read data
//   err_cnt_*_o          saturating mismatch counters per port
//   first_err_addr_*_o   address of the first mismatch per port
module tdp_bram_bist #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 36,
    parameter int unsigned ADDR_INCR    = 1,
    parameter logic [19:0] SALT         = 20'h55000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ERR_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    output logic                  a_wen_o,
    output logic                  a_ren_o,
    output logic [DATA_WIDTH-1:0] a_wdata_o,
    input  logic [DATA_WIDTH-1:0] a_rdata_i,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    output logic                  b_wen_o,
    output logic                  b_ren_o,
    output logic [DATA_WIDTH-1:0] b_wdata_o,
    input  logic [DATA_WIDTH-1:0] b_rdata_i,
    output logic [ERR_WIDTH-1:0]  err_cnt_a_o,
    output logic [ERR_WIDTH-1:0]  err_cnt_b_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_a_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_b_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned Half  = Depth / 2;

    // One extra bit so the end-of-sequence compare never wraps at Depth-1.
    typedef logic [ADDR_WIDTH:0] addr_x_t;

    localparam addr_x_t                 HalfX     = addr_x_t'(Half);
    localparam addr_x_t                 DepthX    = addr_x_t'(Depth);
    localparam addr_x_t                 IncrX     = addr_x_t'(ADDR_INCR);
    localparam logic [ADDR_WIDTH-1:0]   HalfA     = ADDR_WIDTH'(Half);
    localparam logic [2:0]              DrainLast = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdDrain,
        StXrd,
        StXrdDrain,
        StDone
    } state_e;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] addr);
        logic [63:0] w;
        w = 64'(addr) | (64'(addr) << 20) | 64'(SALT);
        return DATA_WIDTH'(w);
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic                  a_wen_q, a_wen_d, b_wen_q, b_wen_d;
    logic                  a_ren_q, a_ren_d, b_ren_q, b_ren_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d, b_wdata_q, b_wdata_d;
    logic [2:0]            drain_q, drain_d;
    logic                  clr_err;

    addr_x_t a_next, b_next, a_lim;
    logic    last_issue;

    assign a_next     = {1'b0, a_addr_q} + IncrX;
    assign b_next     = {1'b0, b_addr_q} + IncrX;
    // Port A walks the upper half only during the cross-read phase.
    assign a_lim      = (state_q == StXrd) ? DepthX : HalfX;
    assign last_issue = (a_next >= a_lim);

    always_comb begin
        state_d   = state_q;
        a_addr_d  = a_addr_q;
        b_addr_d  = b_addr_q;
        a_wen_d   = 1'b0;
        b_wen_d   = 1'b0;
        a_ren_d   = 1'b0;
        b_ren_d   = 1'b0;
        a_wdata_d = a_wdata_q;
        b_wdata_d = b_wdata_q;
        drain_d   = drain_q;
        clr_err   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d   = StWr;
                    clr_err   = 1'b1;
                    a_addr_d  = '0;
                    b_addr_d  = HalfA;
                    a_wen_d   = 1'b1;
                    b_wen_d   = 1'b1;
                    a_wdata_d = pattern('0);
                    b_wdata_d = pattern(HalfA);
                end
            end
            StWr: begin
                if (last_issue) begin
                    state_d  = StRd;
                    a_addr_d = '0;
                    b_addr_d = HalfA;
                    a_ren_d  = 1'b1;
                    b_ren_d  = 1'b1;
                end else begin
                    a_addr_d  = a_next[ADDR_WIDTH-1:0];
                    b_addr_d  = b_next[ADDR_WIDTH-1:0];
                    a_wen_d   = 1'b1;
                    b_wen_d   = 1'b1;
                    a_wdata_d = pattern(a_next[ADDR_WIDTH-1:0]);
                    b_wdata_d = pattern(b_next[ADDR_WIDTH-1:0]);
                end
            end
            StRd, StXrd: begin
                if (last_issue) begin
                    state_d = (state_q == StRd) ? StRdDrain : StXrdDrain;
                    drain_d = '0;
                end else begin
                    a_addr_d = a_next[ADDR_WIDTH-1:0];
                    b_addr_d = b_next[ADDR_WIDTH-1:0];
                    a_ren_d  = 1'b1;
                    b_ren_d  = 1'b1;
                end
            end
            StRdDrain: begin
                if (drain_q == DrainLast) begin
                    state_d  = StXrd;
                    a_addr_d = HalfA;
                    b_addr_d = '0;
                    a_ren_d  = 1'b1;
                    b_ren_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            StXrdDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            a_wen_q   <= 1'b0;
            b_wen_q   <= 1'b0;
            a_ren_q   <= 1'b0;
            b_ren_q   <= 1'b0;
            a_wdata_q <= '0;
            b_wdata_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            a_wen_q   <= a_wen_d;
            b_wen_q   <= b_wen_d;
            a_ren_q   <= a_ren_d;
            b_ren_q   <= b_ren_d;
            a_wdata_q <= a_wdata_d;
            b_wdata_q <= b_wdata_d;
            drain_q   <= drain_d;
        end
    end

    // Compare pipeline: one entry per issued read, aligned with the RAM read latency.
    logic                  a_pv_q [READ_LATENCY];
    logic                  b_pv_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] a_pa_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] b_pa_q [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                a_pv_q[i] <= 1'b0;
                b_pv_q[i] <= 1'b0;
                a_pa_q[i] <= '0;
                b_pa_q[i] <= '0;
            end
        end else begin
            a_pv_q[0] <= a_ren_q;
            b_pv_q[0] <= b_ren_q;
            a_pa_q[0] <= a_addr_q;
            b_pa_q[0] <= b_addr_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                a_pv_q[i] <= a_pv_q[i-1];
                b_pv_q[i] <= b_pv_q[i-1];
                a_pa_q[i] <= a_pa_q[i-1];
                b_pa_q[i] <= b_pa_q[i-1];
            end
        end
    end

    logic [ADDR_WIDTH-1:0] a_tail_addr, b_tail_addr;
    logic                  a_mis, b_mis;

    assign a_tail_addr = a_pa_q[READ_LATENCY-1];
    assign b_tail_addr = b_pa_q[READ_LATENCY-1];
    // Case inequality so X/Z read data counts as a mismatch in simulation.
    assign a_mis = a_pv_q[READ_LATENCY-1] && (a_rdata_i !== pattern(a_tail_addr));
    assign b_mis = b_pv_q[READ_LATENCY-1] && (b_rdata_i !== pattern(b_tail_addr));

    logic [ERR_WIDTH-1:0]  err_a_q, err_a_d, err_b_q, err_b_d;
    logic [ADDR_WIDTH-1:0] fea_q, fea_d, feb_q, feb_d;

    always_comb begin
        err_a_d = err_a_q;
        err_b_d = err_b_q;
        fea_d   = fea_q;
        feb_d   = feb_q;
        if (clr_err) begin
            err_a_d = '0;
            err_b_d = '0;
            fea_d   = '0;
            feb_d   = '0;
        end else begin
            if (a_mis) begin
                if (err_a_q == '0) fea_d = a_tail_addr;
                if (err_a_q != '1) err_a_d = err_a_q + 1'b1;
            end
            if (b_mis) begin
                if (err_b_q == '0) feb_d = b_tail_addr;
                if (err_b_q != '1) err_b_d = err_b_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_a_q <= '0;
            err_b_q <= '0;
            fea_q   <= '0;
            feb_q   <= '0;
        end else begin
            err_a_q <= err_a_d;
            err_b_q <= err_b_d;
            fea_q   <= fea_d;
            feb_q   <= feb_d;
        end
    end

    assign busy_o             = (state_q != StIdle) && (state_q != StDone);
    assign done_o             = (state_q == StDone);
    assign pass_o             = done_o && (err_a_q == '0) && (err_b_q == '0);
    assign a_addr_o           = a_addr_q;
    assign b_addr_o           = b_addr_q;
    assign a_wen_o            = a_wen_q;
    assign b_wen_o            = b_wen_q;
    assign a_ren_o            = a_ren_q;
    assign b_ren_o            = b_ren_q;
    assign a_wdata_o          = a_wdata_q;
    assign b_wdata_o          = b_wdata_q;
    assign err_cnt_a_o        = err_a_q;
    assign err_cnt_b_o        = err_b_q;
    assign first_err_addr_a_o = fea_q;
    assign first_err_addr_b_o = feb_q;

endmodule

// File: tb/tb_tdp_bram_bist.sv
// Bench for tdp_bram_bist: two instances (stride 1 / latency 1 and stride 3 /
// latency 2 with 2-bit counters) each driving a behavioural TDP RAM with
// optional stuck-bit, dropped-write and corrupt-all faults.
module tb_tdp_bram_bist;

    localparam int AW   = 4;
    localparam int DW   = 36;
    localparam int DEPTH = 16;
    localparam int HALF  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    // Fault controls
    bit       st_en = 0;
    int       st_addr = 0;
    int       st_bit = 0;
    logic     st_val = 1'b0;
    bit       drop_en = 0;
    int       drop_addr = 0;
    bit       corrupt1 = 0;

    // ---------------- DUT0: INCR=1, RL=1, ERR_WIDTH=16
    logic          rst0, start0, busy0, done0, pass0;
    logic [AW-1:0] a_addr0, b_addr0, fa0, fb0;
    logic          a_wen0, b_wen0, a_ren0, b_ren0;
    logic [DW-1:0] a_wdata0, b_wdata0, a_rdata0, b_rdata0;
    logic [15:0]   err_a0, err_b0;

    tdp_bram_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_INCR(1), .SALT(20'h55000),
        .READ_LATENCY(1), .ERR_WIDTH(16)
    ) dut0 (
        .clk(clk), .rst(rst0), .start_i(start0), .busy_o(busy0), .done_o(done0),
        .pass_o(pass0), .a_addr_o(a_addr0), .a_wen_o(a_wen0), .a_ren_o(a_ren0),
        .a_wdata_o(a_wdata0), .a_rdata_i(a_rdata0), .b_addr_o(b_addr0), .b_wen_o(b_wen0),
        .b_ren_o(b_ren0), .b_wdata_o(b_wdata0), .b_rdata_i(b_rdata0),
        .err_cnt_a_o(err_a0), .err_cnt_b_o(err_b0),
        .first_err_addr_a_o(fa0), .first_err_addr_b_o(fb0)
    );

    // ---------------- DUT1: INCR=3, RL=2, ERR_WIDTH=2
    logic          rst1, start1, busy1, done1, pass1;
    logic [AW-1:0] a_addr1, b_addr1, fa1, fb1;
    logic          a_wen1, b_wen1, a_ren1, b_ren1;
    logic [DW-1:0] a_wdata1, b_wdata1, a_rdata1, b_rdata1;
    logic [1:0]    err_a1, err_b1;

    tdp_bram_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_INCR(3), .SALT(20'h55000),
        .READ_LATENCY(2), .ERR_WIDTH(2)
    ) dut1 (
        .clk(clk), .rst(rst1), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .pass_o(pass1), .a_addr_o(a_addr1), .a_wen_o(a_wen1), .a_ren_o(a_ren1),
        .a_wdata_o(a_wdata1), .a_rdata_i(a_rdata1), .b_addr_o(b_addr1), .b_wen_o(b_wen1),
        .b_ren_o(b_ren1), .b_wdata_o(b_wdata1), .b_rdata_i(b_rdata1),
        .err_cnt_a_o(err_a1), .err_cnt_b_o(err_b1),
        .first_err_addr_a_o(fa1), .first_err_addr_b_o(fb1)
    );

    // Expected pattern, straight from the formula.
    function automatic logic [DW-1:0] p(input int a);
        logic [63:0] w;
        w = 64'(a) | (64'(a) << 20) | 64'h55000;
        return 36'(w);
    endfunction

    function automatic logic [DW-1:0] fault0(input int a, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (st_en && a == st_addr) r[st_bit] = st_val;
        return r;
    endfunction

    // ---------------- RAM models
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] init0 [DEPTH];
    bit            load0 = 0;

    always @(posedge clk) begin
        if (load0) begin
            for (int i = 0; i < DEPTH; i++) mem0[i] <= init0[i];
        end else begin
            if (a_wen0) mem0[a_addr0] <= a_wdata0;
            if (b_wen0 && !(drop_en && int'(b_addr0) == drop_addr)) mem0[b_addr0] <= b_wdata0;
        end
        if (a_ren0) a_rdata0 <= fault0(int'(a_addr0), mem0[a_addr0]);
        if (b_ren0) b_rdata0 <= fault0(int'(b_addr0), mem0[b_addr0]);
    end

    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] init1 [DEPTH];
    bit            load1 = 0;
    logic [DW-1:0] a_s1, b_s1;

    always @(posedge clk) begin
        if (load1) begin
            for (int i = 0; i < DEPTH; i++) mem1[i] <= init1[i];
        end else begin
            if (a_wen1) mem1[a_addr1] <= a_wdata1;
            if (b_wen1) mem1[b_addr1] <= b_wdata1;
        end
        if (a_ren1) a_s1 <= corrupt1 ? ~mem1[a_addr1] : mem1[a_addr1];
        if (b_ren1) b_s1 <= corrupt1 ? ~mem1[b_addr1] : mem1[b_addr1];
        a_rdata1 <= a_s1;
        b_rdata1 <= b_s1;
    end

    // ---------------- reference model of one complete run
    function automatic void model(input int incr, input int emax, input bit is1,
                                  input logic [DW-1:0] im [DEPTH],
                                  output int ea, output int eb, output int fa, output int fb);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] v;
        int n, xa, xb;
        m  = im;
        n  = (HALF + incr - 1) / incr;
        ea = 0; eb = 0; fa = 0; fb = 0;
        for (int k = 0; k < n; k++) begin
            m[k*incr] = p(k*incr);
            if (is1 || !(drop_en && HALF + k*incr == drop_addr)) m[HALF + k*incr] = p(HALF + k*incr);
        end
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < n; k++) begin
                xa = (ph == 0) ? k*incr : HALF + k*incr;
                xb = (ph == 0) ? HALF + k*incr : k*incr;
                v = m[xa];
                if (!is1 && st_en && xa == st_addr) v[st_bit] = st_val;
                if (is1 && corrupt1) v = ~v;
                if (v !== p(xa)) begin
                    if (ea == 0) fa = xa;
                    if (ea < emax) ea++;
                end
                v = m[xb];
                if (!is1 && st_en && xb == st_addr) v[st_bit] = st_val;
                if (is1 && corrupt1) v = ~v;
                if (v !== p(xb)) begin
                    if (eb == 0) fb = xb;
                    if (eb < emax) eb++;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rand_init(input bit is1);
        logic [63:0] r;
        for (int i = 0; i < DEPTH; i++) begin
            r = {$urandom(), $urandom()};
            if (is1) init1[i] = 36'(r);
            else init0[i] = 36'(r);
        end
    endtask

    task automatic load_mem(input bit is1);
        @(negedge clk);
        if (is1) load1 = 1; else load0 = 1;
        @(negedge clk);
        load0 = 0;
        load1 = 0;
    endtask

    // Run dut0 to completion and check against the model.
    task automatic run0(input string tag, input bit poke);
        int busy_n, coll, ea, eb, fa, fb;
        bit poked;
        logic [DW-1:0] wd3;
        busy_n = 0; coll = 0; poked = 0; wd3 = 'x;
        load_mem(0);
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        for (int c = 0; c < 200; c++) begin
            if (done0) break;
            if (busy0) busy_n++;
            if ((a_wen0 || a_ren0) && (b_wen0 || b_ren0) && a_addr0 == b_addr0) coll++;
            if (a_wen0 && a_addr0 == 4'd3) wd3 = a_wdata0;
            start0 = 0;
            if (poke && !poked && a_ren0 && a_addr0 >= 4'd8) begin
                start0 = 1;
                poked  = 1;
            end
            @(negedge clk);
        end
        start0 = 0;
        model(1, 65535, 0, init0, ea, eb, fa, fb);
        chk({tag, ".done"}, done0, 1);
        chk({tag, ".busy_cycles"}, busy_n, 3*8 + 2*1);
        chk({tag, ".collisions"}, coll, 0);
        chk({tag, ".wdata3"}, wd3, p(3));
        chk({tag, ".err_a"}, err_a0, ea);
        chk({tag, ".err_b"}, err_b0, eb);
        chk({tag, ".first_a"}, fa0, fa);
        chk({tag, ".first_b"}, fb0, fb);
        chk({tag, ".pass"}, pass0, (ea == 0 && eb == 0));
    endtask

    task automatic run1(input string tag);
        int busy_n, rena, renb, ea, eb, fa, fb;
        int wa[$];
        int wb[$];
        busy_n = 0; rena = 0; renb = 0;
        load_mem(1);
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        for (int c = 0; c < 200; c++) begin
            if (done1) break;
            if (busy1) busy_n++;
            if (a_ren1) rena++;
            if (b_ren1) renb++;
            if (a_wen1) wa.push_back(int'(a_addr1));
            if (b_wen1) wb.push_back(int'(b_addr1));
            @(negedge clk);
        end
        model(3, 3, 1, init1, ea, eb, fa, fb);
        chk({tag, ".done"}, done1, 1);
        chk({tag, ".busy_cycles"}, busy_n, 3*3 + 2*2);
        chk({tag, ".reads_a"}, rena, 6);
        chk({tag, ".reads_b"}, renb, 6);
        chk({tag, ".nwrites"}, wa.size() + wb.size(), 6);
        for (int k = 0; k < 3 && k < wa.size() && k < wb.size(); k++) begin
            chk($sformatf("%s.wa%0d", tag, k), wa[k], 3*k);
            chk($sformatf("%s.wb%0d", tag, k), wb[k], HALF + 3*k);
        end
        chk({tag, ".err_a"}, err_a1, ea);
        chk({tag, ".err_b"}, err_b1, eb);
        chk({tag, ".first_a"}, fa1, fa);
        chk({tag, ".first_b"}, fb1, fb);
        chk({tag, ".pass"}, pass1, (ea == 0 && eb == 0));
    endtask

    initial begin
        int nrd;
        rst0 = 1; rst1 = 1; start0 = 0; start1 = 0;
        repeat (3) @(negedge clk);
        chk("rst.ctl0", {busy0, done0, pass0, a_wen0, b_wen0, a_ren0, b_ren0}, 0);
        chk("rst.addr0", {a_addr0, b_addr0, fa0, fb0}, 0);
        chk("rst.wdata0", {a_wdata0, b_wdata0}, 0);
        chk("rst.err0", {err_a0, err_b0}, 0);
        chk("rst.ctl1", {busy1, done1, pass1, a_wen1, b_wen1, a_ren1, b_ren1, err_a1, err_b1}, 0);
        rst0 = 0; rst1 = 0;
        @(negedge clk);
        chk("idle.after_rst", {busy0, done0, a_wen0, a_ren0}, 0);

        // Ideal RAM
        rand_init(0);
        run0("pass", 0);

        // Stuck bit 0 of word 5
        st_en = 1; st_addr = 5; st_bit = 0; st_val = 1'b0;
        rand_init(0);
        run0("stuck5", 0);
        chk("stuck5.err_a_abs", err_a0, 1);
        chk("stuck5.first_b_abs", fb0, 5);
        st_en = 0;

        // Port B writes to address 12 are lost
        drop_en = 1; drop_addr = 12;
        rand_init(0);
        init0[12] = ~p(12);
        run0("drop12", 0);
        chk("drop12.first_b_abs", fb0, 12);
        drop_en = 0;

        // Random stuck-at faults
        for (int t = 0; t < 4; t++) begin
            st_en = 1;
            st_addr = $urandom_range(0, DEPTH - 1);
            st_bit  = $urandom_range(0, DW - 1);
            st_val  = 1'($urandom_range(0, 1));
            rand_init(0);
            run0($sformatf("rnd%0d", t), 0);
        end
        st_en = 0;

        // Reset during the 4th RD cycle
        rand_init(0);
        load_mem(0);
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        nrd = 0;
        for (int c = 0; c < 100; c++) begin
            if (a_ren0) nrd++;
            if (nrd == 4) break;
            @(negedge clk);
        end
        chk("midrst.reached", nrd, 4);
        rst0 = 1;
        @(negedge clk);
        chk("midrst.en", {a_wen0, b_wen0, a_ren0, b_ren0}, 0);
        chk("midrst.busy", {busy0, done0}, 0);
        chk("midrst.err", {err_a0, err_b0}, 0);
        rst0 = 0;
        rand_init(0);
        run0("after_rst", 0);

        // start_i during XRD must be ignored
        rand_init(0);
        run0("poke_xrd", 1);

        // Stride 3, latency 2
        rand_init(1);
        run1("stride");

        // Every read corrupted: 2-bit counters saturate at 3
        corrupt1 = 1;
        rand_init(1);
        run1("sat");
        chk("sat.err_a_abs", err_a1, 3);
        chk("sat.err_b_abs", err_b1, 3);
        corrupt1 = 0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/tdp_bram_bist.md
Name: tdp_bram_bist

Overview:
- Synthesizable built-in self-test engine for one true-dual-port block RAM instance (qlf_k6n10f TDP36K-class primitives and their inferred wrappers), parametrised in width, depth, address stride and read latency.
- Drives both RAM ports from one clock.
- Each port first writes and reads back its own half of the address space. A cross-read phase then has each port read the other port's half, which checks port-to-port coherence.
- Mismatches are counted per port, the first failing address is captured, and a pass/fail summary is reported.

Parameters:
- ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH, HALF = depth/2.
- DATA_WIDTH, 36, RAM data width (1..36).
- ADDR_INCR, 1, address stride within each half (>=1).
- SALT, 20'h55000, constant ORed into every pattern word.
- READ_LATENCY, 1, RAM read latency in cycles from issued read to valid rdata (1..4).
- ERR_WIDTH, 16, width of the error counters.

Ports:
- clk  in  1  single clock for the BIST and both RAM ports
- rst  in  1  synchronous, active-high reset
- start_i  in  1  pulse that starts a run; sampled only in IDLE/DONE
- busy_o  out  1  high while a run is in progress
- done_o  out  1  high from run end until the next accepted start or reset
- pass_o  out  1  valid when done_o; 1 iff both error counters are zero
- a_addr_o / b_addr_o  out  ADDR_WIDTH  port A/B address
- a_wen_o / b_wen_o  out  1  port A/B write enable
- a_ren_o / b_ren_o  out  1  port A/B read enable
- a_wdata_o / b_wdata_o  out  DATA_WIDTH  port A/B write data
- a_rdata_i / b_rdata_i  in  DATA_WIDTH  port A/B read data
- err_cnt_a_o / err_cnt_b_o  out  ERR_WIDTH  mismatch count per port, saturating
- first_err_addr_a_o / first_err_addr_b_o  out  ADDR_WIDTH  address of the first mismatch per port

Behaviour:
- Pattern: P(addr) = (addr | addr<<20 | SALT) truncated to DATA_WIDTH.
- Reset: state = IDLE; busy_o, done_o, pass_o, all wen/ren = 0; all addresses, wdata, error counters, first_err addresses = 0; compare pipeline flushed.
- An asserted rst mid-run aborts within the same edge. No RAM write or read is issued in the following cycle.

State machine (IDLE, WR, RD, RD_DRAIN, XRD, XRD_DRAIN, DONE):
- IDLE/DONE with start_i=1: clear counters, first_err addresses, done_o and pass_o; go to WR.
- start_i in any other state is ignored.
- WR, one issue per cycle:
  - Port A writes addresses 0, ADDR_INCR, ... while addr < HALF.
  - Port B writes addresses HALF, HALF+ADDR_INCR, ... while addr < depth.
  - wdata = P(addr), wen = 1.
  - Number of issues N = ceil(HALF/ADDR_INCR). After N cycles go to RD.
- RD: same address sequences with ren = 1, wen = 0; N cycles, then RD_DRAIN.
- RD_DRAIN: READ_LATENCY cycles with ren = 0, then XRD.
- XRD: port A reads the upper-half sequence and port B reads the lower-half sequence; N cycles, then XRD_DRAIN.
- XRD_DRAIN: READ_LATENCY cycles, then DONE.
- DONE: done_o = 1, busy_o = 0, pass_o = (err_cnt_a==0 && err_cnt_b==0).
- busy_o is 1 in WR through XRD_DRAIN.
- Total busy cycles = 3N + 2*READ_LATENCY.

Address and enable rules:
- Addresses and enables are registered outputs, asserted on the cycle after the state entry edge.
- The address loop terminates on the compare next_addr >= limit. This is computed at ADDR_WIDTH+1 bits so there is no wrap at depth-1.
- A and B never access the same address in the same cycle, because they are always in opposite halves.

Compare pipeline:
- Each issued read pushes {valid, addr, P(addr)} into a READ_LATENCY-deep shift register per port.
- When the tail entry is valid, rdata is compared against it using !== semantics; X or Z counts as a mismatch in simulation.
- On a mismatch: the counter increments, saturating at all-ones. On the first mismatch of the run, the entry's address is captured into first_err_addr.
- Exactly one compare per issued read; none during WR.

Test Plan:
- Pass run: ADDR_WIDTH=4, DATA_WIDTH=36, READ_LATENCY=1, ideal TDP model; start pulse -> busy for 26 cycles; a_wdata_o at addr 3 = 36'h000355003; done_o=1, pass_o=1, both counters 0.
- Stuck bit: model forces bit 0 of word 5 to 0 -> err_cnt_a=1 (RD), err_cnt_b=1 (XRD), first_err_addr_a=5, first_err_addr_b=5, pass_o=0.
- Port-isolation fault: model drops port B writes to address 12 -> err_cnt_b=1 with first_err_addr_b=12 (RD); err_cnt_a=1 with first_err_addr_a=12 (XRD).
- Stride/latency: ADDR_INCR=3, READ_LATENCY=2 -> N=3; A writes 0,3,6 and B writes 8,11,14; busy 13 cycles; 6 compares per port; pass_o=1.
- Reset mid-run: assert rst during the 4th RD cycle -> next cycle all enables 0, busy_o=0, counters 0; a new start completes a clean pass.
- Start ignored/saturation: start_i pulsed during XRD -> no restart, cycle count unchanged; ERR_WIDTH=2 with every read corrupted -> counters stop at 3.
